ysyx_22040759_axi_arbiter: RTL and testbench

YSYX_22040759_AXI_ARBITER -- requirements
Module: ysyx_22040759_axi_arbiter

---
 rtl/ysyx_22040759_axi_arbiter.sv | 165 ++++++++++++++++
 tb/tb_ysyx_22040759_axi_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040759_axi_arbiter.sv
// Two-master arbiter: instruction fetch and data access share one AXI bridge port.
// Define YSYX_22040759_ARB_RR_EN for alternating tie-breaks; by default data wins with a starvation guard.
`timescale 1ns/1ps

module ysyx_22040759_axi_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [63:0] if_data_read,
    input  logic        mem_valid,
    input  logic        mem_req,
    input  logic [31:0] mem_addr,
    input  logic [2:0]  mem_size,
    input  logic [63:0] mem_data_write,
    output logic        mem_ready,
    output logic [63:0] mem_data_read,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic [2:0]  bus_size,
    output logic [63:0] bus_data_write,
    input  logic [63:0] bus_data_read
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } state_t;

    localparam logic [2:0] FETCH_SIZE = 3'b011;

    state_t      state_reg;
    logic        bus_req_reg;
    logic [31:0] bus_addr_reg;
    logic [2:0]  bus_size_reg;
    logic [63:0] bus_data_write_reg;

    logic grant_if;
    logic grant_mem;

`ifdef YSYX_22040759_ARB_RR_EN
    // Set means the fetch side wins the next tie (it was not granted last).
    logic prefer_if_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prefer_if_reg <= 1'b1;
        end else if (grant_if) begin
            prefer_if_reg <= 1'b0;
        end else if (grant_mem) begin
            prefer_if_reg <= 1'b1;
        end
    end
`else
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0] starve_reg;

    // Counts data grants that overtook a waiting fetch; only meaningful in IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_reg <= 4'd0;
        end else if (state_reg == IDLE) begin
            if (!if_valid || grant_if) begin
                starve_reg <= 4'd0;
            end else if (grant_mem && (starve_reg != STARVE_MAX)) begin
                starve_reg <= starve_reg + 4'd1;
            end
        end
    end
`endif

    always_comb begin
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        if (state_reg == IDLE) begin
            if (if_valid && mem_valid) begin
`ifdef YSYX_22040759_ARB_RR_EN
                if (prefer_if_reg) begin
                    grant_if = 1'b1;
                end else begin
                    grant_mem = 1'b1;
                end
`else
                if (starve_reg == STARVE_MAX) begin
                    grant_if = 1'b1;
                end else begin
                    grant_mem = 1'b1;
                end
`endif
            end else if (if_valid) begin
                grant_if = 1'b1;
            end else if (mem_valid) begin
                grant_mem = 1'b1;
            end
        end
    end

    // Bus request fields are captured once at grant and held for the whole transfer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg          <= IDLE;
            bus_req_reg        <= 1'b0;
            bus_addr_reg       <= 32'd0;
            bus_size_reg       <= 3'd0;
            bus_data_write_reg <= 64'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_if) begin
                        state_reg          <= IF_BUSY;
                        bus_req_reg        <= 1'b0;
                        bus_addr_reg       <= if_addr;
                        bus_size_reg       <= FETCH_SIZE;
                        bus_data_write_reg <= 64'd0;
                    end else if (grant_mem) begin
                        state_reg          <= MEM_BUSY;
                        bus_req_reg        <= mem_req;
                        bus_addr_reg       <= mem_addr;
                        bus_size_reg       <= mem_size;
                        bus_data_write_reg <= mem_data_write;
                    end
                end
                IF_BUSY, MEM_BUSY: begin
                    if (bus_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus_valid      = (state_reg != IDLE);
    assign bus_req        = bus_req_reg;
    assign bus_addr       = bus_addr_reg;
    assign bus_size       = bus_size_reg;
    assign bus_data_write = bus_data_write_reg;

    // Index 0 is fetch, index 1 is data; completion is forwarded in the bus_ready cycle.
    logic [1:0]  owner_busy;
    logic [1:0]  owner_ready;
    logic [63:0] owner_data [2];

    assign owner_busy = {state_reg == MEM_BUSY, state_reg == IF_BUSY};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_owner
            assign owner_ready[gi] = owner_busy[gi] & bus_ready;
            assign owner_data[gi]  = owner_ready[gi] ? bus_data_read : 64'd0;
        end
    endgenerate

    assign if_ready      = owner_ready[0];
    assign if_data_read  = owner_data[0];
    assign mem_ready     = owner_ready[1];
    assign mem_data_read = owner_data[1];

endmodule

// File: tb/tb_ysyx_22040759_axi_arbiter.sv
// Self-checking bench for ysyx_22040759_axi_arbiter: vector table, scoreboard queue, corner sequences.
`timescale 1ns/1ps

module tb_ysyx_22040759_axi_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic        if_ready;
    logic [63:0] if_data_read;
    logic        mem_valid = 1'b0;
    logic        mem_req = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [2:0]  mem_size = 3'd0;
    logic [63:0] mem_data_write = 64'd0;
    logic        mem_ready;
    logic [63:0] mem_data_read;
    logic        bus_valid;
    logic        bus_ready = 1'b0;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [2:0]  bus_size;
    logic [63:0] bus_data_write;
    logic [63:0] bus_data_read = 64'd0;

    always #5 clock = ~clock;

    ysyx_22040759_axi_arbiter #(.STARVE_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready), .if_data_read(if_data_read),
        .mem_valid(mem_valid), .mem_req(mem_req), .mem_addr(mem_addr), .mem_size(mem_size),
        .mem_data_write(mem_data_write), .mem_ready(mem_ready), .mem_data_read(mem_data_read),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_req(bus_req), .bus_addr(bus_addr),
        .bus_size(bus_size), .bus_data_write(bus_data_write), .bus_data_read(bus_data_read)
    );

    typedef struct {
        logic        is_mem;
        logic        req;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          lat;
        logic        drop;
    } vec_t;

    typedef struct {
        logic        is_mem;
        logic        req;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [63:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic idle_inputs();
        if_valid       = 1'b0;
        mem_valid      = 1'b0;
        mem_req        = 1'b0;
        bus_ready      = 1'b0;
        bus_data_read  = 64'hBAD0_BAD0_BAD0_BAD0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        @(negedge clock);
        if (v.is_mem) begin
            if_valid = 1'b0;
            mem_valid = 1'b1; mem_req = v.req; mem_addr = v.addr;
            mem_size = v.size; mem_data_write = v.wdata;
        end else begin
            if_valid = 1'b1; if_addr = v.addr;
            mem_valid = 1'b0; mem_req = 1'b1; mem_addr = 32'hCAFE_0000;
            mem_size = 3'b101; mem_data_write = 64'hFFFF_0000_FFFF_0000;
        end
        e.is_mem = v.is_mem;
        e.req    = v.is_mem ? v.req : 1'b0;
        e.addr   = v.addr;
        e.size   = v.is_mem ? v.size : 3'b011;
        e.wdata  = v.is_mem ? v.wdata : 64'd0;
        e.rdata  = v.rdata;
        sb.push_back(e);
        #2 chk("pre_grant_valid", bus_valid, 0);
        for (int c = 1; c <= v.lat; c++) begin
            @(negedge clock);
            if (v.drop && c == 1) begin
                if_valid = 1'b0;
                mem_valid = 1'b0;
            end
            if (c == v.lat) begin
                bus_ready = 1'b1;
                bus_data_read = v.rdata;
            end
            #2;
            chk("busy_valid", bus_valid, 1);
            if (c < v.lat) begin
                chk("early_ready", {if_ready, mem_ready}, 0);
                chk("gated_data", if_data_read | mem_data_read, 0);
            end else begin
                e = sb.pop_front();
                chk("owner_ready", {if_ready, mem_ready}, e.is_mem ? 2'b01 : 2'b10);
                chk("owner_data", e.is_mem ? mem_data_read : if_data_read, e.rdata);
                chk("other_data", e.is_mem ? if_data_read : mem_data_read, 0);
                chk("bus_req", bus_req, e.req);
                chk("bus_addr", bus_addr, e.addr);
                chk("bus_size", bus_size, e.size);
                chk("bus_wdata", bus_data_write, e.wdata);
            end
        end
        @(negedge clock);
        idle_inputs();
        #2 chk("release_valid", bus_valid, 0);
        $display("txn %0d %s req=%0b addr=%h lat=%0d drop=%0b", idx, v.is_mem ? "mem" : "if",
                 v.req, v.addr, v.lat, v.drop);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        int   order_q[$];
        int   grants;
        int   cycles;
        int   exp_owner;

        vecs[0] = '{1'b0, 1'b0, 32'h8000_0000, 3'd0, 64'd0, 64'h0000_0013_0000_0093, 3, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 32'h8000_1000, 3'd3, 64'h0000_0000_DEAD_BEEF, 64'h1111_2222_3333_4444, 2, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'h8000_2008, 3'd2, 64'h7777_7777_7777_7777, 64'h1122_3344_5566_7788, 1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h8000_0004, 3'd0, 64'd0, 64'hFEED_FACE_0BAD_F00D, 4, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 32'h1000_0000, 3'd0, 64'h0000_0000_0000_00A5, 64'h0, 1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h8000_3010, 3'd1, 64'd0, 64'h0000_0000_0000_BEEF, 2, 1'b1};

        idle_inputs();
        @(negedge clock);
        #2;
        chk("reset_bus_valid", bus_valid, 0);
        chk("reset_ready", {if_ready, mem_ready}, 0);
        chk("reset_bus_regs", {bus_req, bus_addr, bus_size}, 0);
        chk("reset_bus_wdata", bus_data_write, 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // Fetch valid left high after its ready: one idle gap, then a fresh request.
        @(negedge clock);
        if_valid = 1'b1; if_addr = 32'h8000_0040;
        @(negedge clock);
        bus_ready = 1'b1; bus_data_read = 64'h0000_0000_0000_0001;
        #2 chk("back2back_first_ready", if_ready, 1);
        @(negedge clock);
        bus_ready = 1'b0;
        #2 chk("back2back_gap", bus_valid, 0);
        @(negedge clock);
        #2 chk("back2back_regrant", bus_valid, 1);
        chk("back2back_no_ready", if_ready, 0);
        @(negedge clock);
        bus_ready = 1'b1; bus_data_read = 64'h0000_0000_0000_0002;
        #2 chk("back2back_second_data", if_data_read, 64'h2);
        @(negedge clock);
        idle_inputs();
        #2 chk("back2back_done", bus_valid, 0);
        $display("txn seq back-to-back fetch");

        // Reset in the middle of a data transfer abandons it without a ready pulse.
        @(negedge clock);
        mem_valid = 1'b1; mem_req = 1'b0; mem_addr = 32'h8000_4000; mem_size = 3'd3;
        @(negedge clock);
        #2 chk("abort_busy", bus_valid, 1);
        @(negedge clock);
        reset = 1'b1;
        #1 chk("abort_valid_now", bus_valid, 0);
        chk("abort_addr_cleared", bus_addr, 0);
        mem_valid = 1'b0; bus_ready = 1'b1; bus_data_read = 64'h5555_5555_5555_5555;
        #1 chk("abort_no_ready_in_reset", mem_ready, 0);
        @(negedge clock);
        reset = 1'b0;
        #2 chk("abort_no_ready", {if_ready, mem_ready}, 0);
        chk("abort_idle", bus_valid, 0);
        $display("txn seq reset mid-transfer");

        // bus_ready seen in IDLE with nothing pending changes nothing.
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            bus_ready = (k == 0);
            bus_data_read = 64'h9999_0000_9999_0000;
            #2 chk("stray_ready_ctrl", {bus_valid, bus_req, bus_addr, bus_size, if_ready, mem_ready}, 0);
            chk("stray_ready_data", if_data_read | mem_data_read | bus_data_write, 0);
        end
        $display("txn seq stray bus_ready");

        // Continuous contention from a clean reset.
        @(negedge clock);
        idle_inputs();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        if_valid = 1'b1; if_addr = 32'h8000_0100;
        mem_valid = 1'b1; mem_req = 1'b0; mem_addr = 32'h8000_2000; mem_size = 3'd3;
        for (int g = 0; g < 10; g++) begin
`ifdef YSYX_22040759_ARB_RR_EN
            order_q.push_back((g % 2 == 0) ? 0 : 1);
`else
            order_q.push_back((g % 5 == 4) ? 0 : 1);
`endif
        end
        grants = 0;
        cycles = 0;
        while (grants < 10 && cycles < 200) begin
            @(negedge clock);
            cycles++;
            bus_ready = 1'b0;
            #1;
            if (bus_valid) begin
                bus_ready = 1'b1;
                bus_data_read = 64'(grants);
                #1;
                exp_owner = order_q.pop_front();
                chk("contend_owner", {if_ready, mem_ready}, (exp_owner == 1) ? 2'b01 : 2'b10);
                chk("contend_addr", bus_addr, (exp_owner == 1) ? 32'h8000_2000 : 32'h8000_0100);
                $display("txn contend %0d winner=%s", grants, if_ready ? "if" : (mem_ready ? "mem" : "none"));
                grants++;
            end
        end
        chk("contend_grant_count", grants, 10);
        @(negedge clock);
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
